// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the
// run/halt/error state type used by the PC update unit.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        INS  = 2'd2
    } state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop compares the popped entry against the memory-supplied return address.
module ras_stack
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              push_data,
    input  logic [ADDR_W-1:0]              cmp_data,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count,
    output logic                           overflow,
    output logic                           underflow,
    output logic                           mismatch
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d, top_dec;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              mismatch_q, mismatch_d;

    // Power-of-two depth lets pointer wrap fall out of the natural width.
    always_comb begin
        mem_d       = mem_q;
        top_d       = top_q;
        top_dec     = top_q - PTR_W'(1);
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mismatch_d  = 1'b0;
        if (push) begin
            mem_d[top_q] = push_data;
            top_d        = top_q + PTR_W'(1);
            if (count_q == CNT_W'(RAS_DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                top_d      = top_dec;
                count_d    = count_q - CNT_W'(1);
                mismatch_d = (mem_q[top_dec] != cmp_data);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            top_q       <= top_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mismatch_q  <= mismatch_d;
        end
    end

    // Entries are only meaningful below count, so they need no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign mismatch  = mismatch_q;

endmodule

// File: rtl/pc_update_ras.sv
// Registered PC unit for the SEQ Y86-64 datapath: PC register, status FSM,
// next-PC select and a return-address stack checked on every ret.
module pc_update_ras
    import y86_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           instr_valid,
    input  logic                           stall,
    input  logic [3:0]                     icode,
    input  logic                           cnd,
    input  logic [ADDR_W-1:0]              valP,
    input  logic [ADDR_W-1:0]              valC,
    input  logic [ADDR_W-1:0]              valM,
    output logic [ADDR_W-1:0]              pc,
    output logic [2:0]                     stat,
    output logic                           ras_mismatch,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic              retire;
    logic              push, pop;

    always_comb begin
        retire  = (state_q == RUN) && instr_valid && !stall;
        pc_d    = pc_q;
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (retire) begin
            case (icode)
                I_HALT: state_d = HALT;
                I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ,
                I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: pc_d = valP;
                I_JXX:  pc_d = cnd ? valC : valP;
                I_CALL: begin
                    pc_d = valC;
                    push = 1'b1;
                end
                I_RET: begin
                    pc_d = valM;
                    pop  = 1'b1;
                end
                default: state_d = INS;
            endcase
        end
        case (state_d)
            HALT:    stat_d = STAT_HLT;
            INS:     stat_d = STAT_INS;
            default: stat_d = STAT_AOK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            stat_q  <= STAT_AOK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
        end
    end

    ras_stack #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(valP),
        .cmp_data (valM),
        .count    (ras_count),
        .overflow (ras_overflow),
        .underflow(ras_underflow),
        .mismatch (ras_mismatch)
    );

    assign pc   = pc_q;
    assign stat = stat_q;

endmodule

// File: tb/tb_pc_update_ras.sv
// Directed bench for pc_update_ras: a queue-based reference model checked every
// cycle, plus literal expectations along the directed sequence.
module tb_pc_update_ras;

    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned RAS_DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic              stall;
    logic [3:0]        icode;
    logic              cnd;
    logic [ADDR_W-1:0] valP, valC, valM;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        stat;
    logic              ras_mismatch;
    logic [3:0]        ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    int checks   = 0;
    int failures = 0;

    pc_update_ras #(
        .ADDR_W   (ADDR_W),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .icode        (icode),
        .cnd          (cnd),
        .valP         (valP),
        .valC         (valC),
        .valM         (valM),
        .pc           (pc),
        .stat         (stat),
        .ras_mismatch (ras_mismatch),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: return addresses as a bounded queue (newest at back).
    logic [63:0] m_pc;
    int          m_stat;
    logic [63:0] m_ras[$];
    logic        m_ovf, m_unf, m_mis;
    bit          m_ready = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 64'h0; m_stat = 1; m_ras.delete();
            m_ovf = 0; m_unf = 0; m_mis = 0; m_ready = 1;
        end else begin
            m_mis = 0;
            if (m_stat == 1 && instr_valid && !stall) begin
                if (icode == 0) m_stat = 2;
                else if (icode >= 4'hC) m_stat = 4;
                else if (icode == 7) m_pc = cnd ? valC : valP;
                else if (icode == 8) begin
                    m_pc = valC;
                    if (m_ras.size() == RAS_DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1;
                    end
                    m_ras.push_back(valP);
                end else if (icode == 9) begin
                    m_pc = valM;
                    if (m_ras.size() == 0) m_unf = 1;
                    else m_mis = (m_ras.pop_back() != valM);
                end else m_pc = valP;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("pc", pc, m_pc);
            chk("stat", 64'(stat), 64'(m_stat));
            chk("ras_count", 64'(ras_count), 64'(m_ras.size()));
            chk("ras_mismatch", 64'(ras_mismatch), 64'(m_mis));
            chk("ras_overflow", 64'(ras_overflow), 64'(m_ovf));
            chk("ras_underflow", 64'(ras_underflow), 64'(m_unf));
        end
    end

    task automatic retire(input logic [3:0] ic, input logic c, input logic [63:0] p,
                          input logic [63:0] cv, input logic [63:0] m, input logic st);
        instr_valid = 1'b1; stall = st; icode = ic; cnd = c;
        valP = p; valC = cv; valM = m;
        @(posedge clk); #1;
        instr_valid = 1'b0; stall = 1'b0;
    endtask

    task automatic do_reset(input logic with_call);
        reset = 1'b1;
        instr_valid = with_call; stall = 1'b0; icode = 4'h8;
        valP = 64'h99; valC = 64'h200; valM = '0;
        @(posedge clk); #1;
        reset = 1'b0; instr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; stall = 1'b0; icode = '0; cnd = 1'b0;
        valP = '0; valC = '0; valM = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_pc", pc, 64'h0);
        chk("reset_stat", 64'(stat), 64'd1);
        chk("reset_count", 64'(ras_count), 64'd0);

        // Plain retire and not-taken jump
        retire(4'h1, 1'b0, 64'h0A, 64'h0, 64'h0, 1'b0);
        chk("t1_pc_nop", pc, 64'h0A);
        retire(4'h7, 1'b0, 64'h13, 64'h40, 64'h0, 1'b0);
        chk("t1_pc_jxx", pc, 64'h13);
        chk("t1_stat", 64'(stat), 64'd1);
        retire(4'h7, 1'b1, 64'h1C, 64'h48, 64'h0, 1'b0);
        chk("t1_pc_taken", pc, 64'h48);

        // Call/ret matched, then mismatched
        retire(4'h8, 1'b0, 64'h20, 64'h100, 64'h0, 1'b0);
        chk("t2_pc_call", pc, 64'h100);
        chk("t2_count1", 64'(ras_count), 64'd1);
        retire(4'h9, 1'b0, 64'h0, 64'h0, 64'h20, 1'b0);
        chk("t2_pc_ret", pc, 64'h20);
        chk("t2_count0", 64'(ras_count), 64'd0);
        chk("t2_nomis", 64'(ras_mismatch), 64'd0);
        retire(4'h8, 1'b0, 64'h20, 64'h100, 64'h0, 1'b0);
        retire(4'h9, 1'b0, 64'h0, 64'h0, 64'h24, 1'b0);
        chk("t2_mis_pulse", 64'(ras_mismatch), 64'd1);
        @(posedge clk); #1;
        chk("t2_mis_clear", 64'(ras_mismatch), 64'd0);

        // Overflow and underflow
        for (int i = 0; i < 9; i++) retire(4'h8, 1'b0, 64'h10 + 64'(i), 64'h200, 64'h0, 1'b0);
        chk("t3_count_full", 64'(ras_count), 64'd8);
        chk("t3_ovf", 64'(ras_overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            retire(4'h9, 1'b0, 64'h0, 64'h0, 64'h18 - 64'(i), 1'b0);
            chk("t3_ret_nomis", 64'(ras_mismatch), 64'd0);
        end
        retire(4'h9, 1'b0, 64'h0, 64'h0, 64'h11, 1'b0);
        chk("t3_unf", 64'(ras_underflow), 64'd1);
        chk("t3_unf_nomis", 64'(ras_mismatch), 64'd0);
        chk("t3_count_empty", 64'(ras_count), 64'd0);

        // Halt is absorbing until reset
        retire(4'h1, 1'b0, 64'h30, 64'h0, 64'h0, 1'b0);
        retire(4'h0, 1'b0, 64'h32, 64'h0, 64'h0, 1'b0);
        chk("t4_halt_pc", pc, 64'h30);
        chk("t4_halt_stat", 64'(stat), 64'd2);
        retire(4'h8, 1'b0, 64'h34, 64'h300, 64'h0, 1'b0);
        chk("t4_after_pc", pc, 64'h30);
        chk("t4_after_count", 64'(ras_count), 64'd0);
        do_reset(1'b0);
        chk("t4_rst_pc", pc, 64'h0);
        chk("t4_rst_stat", 64'(stat), 64'd1);
        chk("t4_rst_unf", 64'(ras_underflow), 64'd0);
        chk("t4_rst_ovf", 64'(ras_overflow), 64'd0);

        // Stall in RUN, then invalid instruction
        retire(4'h8, 1'b0, 64'h04, 64'h80, 64'h0, 1'b1);
        chk("t5_stall_pc", pc, 64'h0);
        chk("t5_stall_count", 64'(ras_count), 64'd0);
        retire(4'h1, 1'b0, 64'h50, 64'h0, 64'h0, 1'b0);
        retire(4'hE, 1'b0, 64'h52, 64'h0, 64'h0, 1'b0);
        chk("t5_ins_stat", 64'(stat), 64'd4);
        chk("t5_ins_pc", pc, 64'h50);
        retire(4'h8, 1'b0, 64'h54, 64'h90, 64'h0, 1'b1);
        chk("t5_stall_ins_pc", pc, 64'h50);
        chk("t5_stall_mis", 64'(ras_mismatch), 64'd0);

        // Reset beats a simultaneous retiring call
        do_reset(1'b0);
        retire(4'h1, 1'b0, 64'h60, 64'h0, 64'h0, 1'b0);
        retire(4'h8, 1'b0, 64'h64, 64'h70, 64'h0, 1'b0);
        chk("t6_pre_count", 64'(ras_count), 64'd1);
        do_reset(1'b1);
        chk("t6_pc", pc, 64'h0);
        chk("t6_count", 64'(ras_count), 64'd0);
        retire(4'h9, 1'b0, 64'h0, 64'h0, 64'h99, 1'b0);
        chk("t6_no_push", 64'(ras_underflow), 64'd1);

        @(posedge clk); @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_update_ras.md
Name: pc_update_ras

Overview:
- Registered program-counter unit for the SEQ Y86-64 datapath. Replaces the purely combinational next-PC select.
- Holds the architectural PC and a run/halt/error status state machine.
- Adds a parametrised return-address stack (RAS) that records call return addresses and flags mismatches against the memory-supplied return address on ret.
- Sits between the memory/writeback stages and fetch. Its pc output drives the fetch address directly.

Parameters:
- ADDR_W, 64, width of PC and all address inputs
- RAS_DEPTH, 8, number of RAS entries (power of two, >= 2)
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  current decoded instruction is complete and may retire this cycle
- stall  in  1  freeze all state this cycle; overrides instr_valid
- icode  in  4  instruction code of the retiring instruction
- cnd  in  1  condition result for jXX
- valP  in  ADDR_W  fall-through address
- valC  in  ADDR_W  constant/target address
- valM  in  ADDR_W  value read from memory (return address on ret)
- pc  out  ADDR_W  current PC
- stat  out  3  1=AOK, 2=HLT, 4=INS
- ras_mismatch  out  1  one-cycle pulse: popped RAS entry != valM on ret
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_overflow  out  1  sticky: a push occurred while full
- ras_underflow  out  1  sticky: a pop occurred while empty

Behaviour:
- Synchronous active-high reset; it wins over every other input, including mid-instruction. Reset values:
  - pc = RESET_PC
  - stat = AOK (state RUN)
  - ras_count = 0; RAS top pointer = 0
  - ras_mismatch = 0, ras_overflow = 0, ras_underflow = 0
- Retire event: state == RUN && instr_valid && !stall. Only a retire event changes pc or the RAS. Latency: new pc is visible the cycle after the retiring edge.
- Next-PC select on retire:
  - icode 0 (halt): pc holds; state -> HALT.
  - 1, 2, 3, 4, 5, 6, A, B: pc = valP.
  - 7 (jXX): pc = cnd ? valC : valP.
  - 8 (call): pc = valC; push valP.
  - 9 (ret): pc = valM; pop and compare.
  - C..F (invalid): pc holds; state -> INS.
- States:
  - RUN: stat = AOK.
  - HALT: stat = HLT.
  - INS: stat = INS.
  - HALT and INS are absorbing; only reset exits them. instr_valid is ignored in both.
- RAS is circular.
  - Push: write at top, top = top + 1 mod RAS_DEPTH, count = min(count + 1, RAS_DEPTH).
  - Push when full: the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow set.
  - Pop when count > 0: top = top - 1 mod RAS_DEPTH, count - 1. Compare the entry at the new top against valM; ras_mismatch = 1 next cycle if they differ.
  - Pop when count == 0: pointer and count unchanged, ras_mismatch = 0, ras_underflow set.
- ras_mismatch is registered and high for exactly one cycle after the ret edge; it is 0 in all other cycles, including stalled ones.
- Stall: pc, state, RAS, count and sticky flags all hold; ras_mismatch = 0.
- Sticky flags clear only on reset.
- Arithmetic: pointer arithmetic is modulo RAS_DEPTH. No PC arithmetic is done here, because valP arrives precomputed.
- pc never changes on a halt or invalid retire, so the faulting PC stays observable.

Decomposition:
- Shared package y86_pkg:
  - icode constants: I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ
  - stat codes: STAT_AOK = 1, STAT_HLT = 2, STAT_INS = 4
  - state enum: RUN, HALT, INS
- One sub-module, ras_stack (params ADDR_W, RAS_DEPTH):
  - inputs: push, pop, push_data, cmp_data
  - outputs: count, overflow, underflow, mismatch
- The top level keeps the PC register, the status FSM and the next-PC mux.

Test Plan:
1. Reset, then retire icode 1 with valP=0x0A, then icode 7 with cnd=0, valC=0x40, valP=0x13 -> pc = 0x0A then 0x13; stat = 1.
2. call with valC=0x100, valP=0x20, then ret with valM=0x20 -> pc = 0x100 then 0x20; ras_count 1 -> 0; ras_mismatch stays 0. Repeat the ret with valM=0x24 after a fresh call -> ras_mismatch pulses for one cycle.
3. Nine calls (RAS_DEPTH=8) with valP=0x10..0x18 -> ras_count = 8, ras_overflow = 1. Nine rets with matching valM 0x18..0x11 -> the first eight show no mismatch; the ninth sets ras_underflow = 1 with no mismatch.
4. halt at pc=0x30 -> pc stays 0x30, stat = 2. Further instr_valid with icode 8 -> no change. Then assert reset -> pc = RESET_PC, stat = 1, ras_count = 0.
5. icode 0xE retired -> stat = 4, pc unchanged. Retire with stall=1 and icode 8 -> pc, ras_count and stat unchanged; ras_mismatch = 0.
6. Assert reset in the same cycle as a retiring call -> reset wins: pc = RESET_PC, ras_count = 0, no push recorded.
